// File: rtl/regfile_write_sequencer.sv
// Single write-port owner for the 32x32 register file: zero-fill sweep after reset,
// then round-robin arbitration between ALU (req 0) and load (req 1) writeback.
module regfile_write_sequencer #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int REGS         = 32,
    parameter bit DISCARD_ZERO = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0_Valid,
    input  logic [ADDR_W-1:0] Req0_Adr,
    input  logic [DATA_W-1:0] Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [ADDR_W-1:0] Req1_Adr,
    input  logic [DATA_W-1:0] Req1_Data,
    output logic              Req1_Ready,
    output logic              WEn,
    output logic [ADDR_W-1:0] Write_Adr,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Init_Busy,
    output logic [15:0]       Stall_Count
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_last;
    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              stall;

    assign cnt_last = (cnt == ADDR_W'(REGS - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt_last) state_nxt = RUN;
    end

    // A tie goes to whichever requester did not win the previous grant.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        stall     = 1'b0;
        Init_Busy = 1'b1;
        if (state == RUN) begin
            Init_Busy = 1'b0;
            grant0    = Req0_Valid & (~Req1_Valid | last_grant);
            grant1    = Req1_Valid & (~Req0_Valid | ~last_grant);
            stall     = (Req0_Valid & ~grant0) | (Req1_Valid & ~grant1);
        end
    end

    assign Req0_Ready = grant0;
    assign Req1_Ready = grant1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Address-0 writes are still accepted; only the enable is suppressed.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            WEn        <= 1'b0;
            Write_Adr  <= '0;
            Write_Data <= '0;
        end else if (state == INIT) begin
            WEn        <= 1'b1;
            Write_Adr  <= cnt;
            Write_Data <= '0;
        end else if (grant0) begin
            WEn        <= ~(DISCARD_ZERO && (Req0_Adr == '0));
            Write_Adr  <= Req0_Adr;
            Write_Data <= Req0_Data;
        end else if (grant1) begin
            WEn        <= ~(DISCARD_ZERO && (Req1_Adr == '0));
            Write_Adr  <= Req1_Adr;
            Write_Data <= Req1_Data;
        end else begin
            WEn        <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Stall_Count <= '0;
        end else if (stall && (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + 16'd1;
        end
    end

endmodule
